// File: rtl/player_missile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : player_missile_ctrl
//  Description : Single-missile launcher/tracker. Launches from the player
//                position on a fire edge, climbs once per frame, retires on a
//                hit or at the top of the screen, then waits a reload delay.
//  Revision    : 1.0  initial release
// ============================================================================
module player_missile_ctrl #(
    parameter int X_OFFSET        = 14,
    parameter int MISSILE_H       = 16,
    parameter int Y_SPEED         = 8,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic        playerDead,
    input  logic        missileHit,
    input  logic [10:0] playerX,
    input  logic [10:0] playerY,
    output logic [10:0] missileX,
    output logic [10:0] missileY,
    output logic        missileActive,
    output logic        shotFired
);

    localparam int          CNT_W         = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [10:0] C_X_OFFSET    = 11'(X_OFFSET);
    localparam logic [10:0] C_MISSILE_H   = 11'(MISSILE_H);
    localparam logic [10:0] C_Y_SPEED     = 11'(Y_SPEED);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      missile_x_q, missile_x_d;
    logic [10:0]      missile_y_q, missile_y_d;
    logic             active_q, active_d;
    logic             shot_q, shot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fire_prev_q, fire_prev_d;
    logic             req_pending_q, req_pending_d;
    logic             armed_q, armed_d;
    logic             fire_rise;

    // armed_q masks the first clock after reset so a key held through reset
    // release is not seen as a fresh press.
    assign fire_rise = fire & ~fire_prev_q & armed_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            missile_x_q   <= '0;
            missile_y_q   <= '0;
            active_q      <= 1'b0;
            shot_q        <= 1'b0;
            cnt_q         <= '0;
            fire_prev_q   <= 1'b0;
            req_pending_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            missile_x_q   <= missile_x_d;
            missile_y_q   <= missile_y_d;
            active_q      <= active_d;
            shot_q        <= shot_d;
            cnt_q         <= cnt_d;
            fire_prev_q   <= fire_prev_d;
            req_pending_q <= req_pending_d;
            armed_q       <= armed_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        missile_x_d   = missile_x_q;
        missile_y_d   = missile_y_q;
        active_d      = active_q;
        shot_d        = 1'b0;
        cnt_d         = cnt_q;
        fire_prev_d   = fire;
        req_pending_d = req_pending_q;
        armed_d       = 1'b1;

        if (playerDead) begin
            state_d       = ST_IDLE;
            active_d      = 1'b0;
            req_pending_d = 1'b0;
            cnt_d         = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startOfFrame && (req_pending_q || fire_rise)) begin
                        missile_x_d   = playerX + C_X_OFFSET;
                        missile_y_d   = (playerY < C_MISSILE_H) ? 11'd0 : playerY - C_MISSILE_H;
                        active_d      = 1'b1;
                        shot_d        = 1'b1;
                        req_pending_d = 1'b0;
                        state_d       = ST_FLYING;
                    end else if (fire_rise) begin
                        req_pending_d = 1'b1;
                    end
                end
                ST_FLYING: begin
                    // A hit in the same clock as a frame tick retires without moving.
                    if (missileHit || (startOfFrame && (missile_y_q < C_Y_SPEED))) begin
                        active_d = 1'b0;
                        if (COOLDOWN_FRAMES == 0) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_COOLDOWN;
                            cnt_d   = C_CNT_LOAD;
                        end
                    end else if (startOfFrame) begin
                        missile_y_d = missile_y_q - C_Y_SPEED;
                    end
                end
                ST_COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    assign missileX      = missile_x_q;
    assign missileY      = missile_y_q;
    assign missileActive = active_q;
    assign shotFired     = shot_q;

endmodule
`default_nettype wire

// File: tb/tb_player_missile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_missile_ctrl
//  Description : Directed vector bench for player_missile_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_player_missile_ctrl;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        fire;
    logic        playerDead;
    logic        missileHit;
    logic [10:0] playerX;
    logic [10:0] playerY;
    logic [10:0] missileX;
    logic [10:0] missileY;
    logic        missileActive;
    logic        shotFired;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic        sof;
        logic        fire;
        logic        dead;
        logic        hit;
        logic [10:0] px;
        logic [10:0] py;
        logic [10:0] ex;
        logic [10:0] ey;
        logic        eact;
        logic        eshot;
    } vec_t;

    vec_t vecs[$];

    player_missile_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .fire         (fire),
        .playerDead   (playerDead),
        .missileHit   (missileHit),
        .playerX      (playerX),
        .playerY      (playerY),
        .missileX     (missileX),
        .missileY     (missileY),
        .missileActive(missileActive),
        .shotFired    (shotFired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [10:0] ex, input logic [10:0] ey,
                              input logic eact, input logic eshot);
        check({tag, ".missileX"}, missileX, ex);
        check({tag, ".missileY"}, missileY, ey);
        check({tag, ".missileActive"}, {10'd0, missileActive}, {10'd0, eact});
        check({tag, ".shotFired"}, {10'd0, shotFired}, {10'd0, eshot});
    endtask

    task automatic add(input logic sof, input logic f, input logic dead, input logic hit,
                       input int px, input int py, input int ex, input int ey,
                       input logic eact, input logic eshot);
        vec_t v;
        v = '{sof, f, dead, hit, 11'(px), 11'(py), 11'(ex), 11'(ey), eact, eshot};
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        startOfFrame = v.sof;
        fire         = v.fire;
        playerDead   = v.dead;
        missileHit   = v.hit;
        playerX      = v.px;
        playerY      = v.py;
        @(posedge clk);
        #1;
        check_outs(tag, v.ex, v.ey, v.eact, v.eshot);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        //   sof fire dead hit  px    py    ex    ey  act shot
        add(0, 0, 0, 0, 320, 450,    0,   0, 0, 0);  // v0  first clk after reset
        add(0, 1, 0, 0, 320, 450,    0,   0, 0, 0);  // v1  rise queues request
        add(1, 1, 0, 0, 320, 450,  334, 434, 1, 1);  // v2  launch
        add(0, 1, 0, 0, 320, 450,  334, 434, 1, 0);  // v3  shot is one clk
        add(1, 1, 0, 0, 320, 450,  334, 426, 1, 0);  // v4
        add(0, 0, 0, 0, 320, 450,  334, 426, 1, 0);  // v5
        add(1, 1, 0, 0, 320, 450,  334, 418, 1, 0);  // v6  re-press ignored in flight
        add(1, 1, 0, 0, 320, 450,  334, 410, 1, 0);  // v7
        add(0, 0, 0, 1, 320, 450,  334, 410, 0, 0);  // v8  hit retires, position held
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v9  cooldown SOF 1, rise ignored
        add(1, 0, 0, 0, 320, 450,  334, 410, 0, 0);  // v10
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v11
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v12
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v13
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v14
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v15
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v16 8th SOF -> idle
        add(1, 1, 0, 0, 320, 450,  334, 410, 0, 0);  // v17 held key does not fire
        add(0, 0, 0, 0, 100,  28,  334, 410, 0, 0);  // v18
        add(1, 1, 0, 0, 100,  28,  114,  12, 1, 1);  // v19 rise+SOF same clk
        add(1, 1, 0, 0, 100,  28,  114,   4, 1, 0);  // v20
        add(1, 1, 0, 0, 100,  28,  114,   4, 0, 0);  // v21 off top
        add(1, 0, 0, 0, 100,  28,  114,   4, 0, 0);  // v22 cooldown SOF 1
        add(1, 1, 0, 0, 100,  28,  114,   4, 0, 0);  // v23
        add(1, 0, 0, 0, 100,  28,  114,   4, 0, 0);  // v24
        add(1, 1, 0, 0, 100,  28,  114,   4, 0, 0);  // v25
        add(1, 0, 0, 0, 100,  28,  114,   4, 0, 0);  // v26
        add(1, 0, 0, 0, 100,  28,  114,   4, 0, 0);  // v27
        add(1, 0, 0, 0, 100,  28,  114,   4, 0, 0);  // v28 7th SOF
        add(0, 1, 0, 0, 100,  28,  114,   4, 0, 0);  // v29 rise still in cooldown
        add(1, 1, 0, 0, 100,  28,  114,   4, 0, 0);  // v30 8th SOF, no launch
        add(0, 0, 0, 0, 100,  28,  114,   4, 0, 0);  // v31
        add(0, 1, 0, 0, 100, 216,  114,   4, 0, 0);  // v32 rise -> pending
        add(1, 0, 0, 0, 100, 216,  114, 200, 1, 1);  // v33 pending launch
        add(1, 0, 0, 1, 100, 216,  114, 200, 0, 0);  // v34 hit beats SOF, no move
        add(0, 0, 1, 0, 100, 216,  114, 200, 0, 0);  // v35 dead clears cooldown
        add(1, 1, 0, 0, 320, 450,  334, 434, 1, 1);  // v36 immediate launch
        add(0, 1, 1, 0, 320, 450,  334, 434, 0, 0);  // v37 dead mid-flight
        add(0, 0, 0, 0, 320, 450,  334, 434, 0, 0);  // v38
        add(1, 1, 0, 0, 320, 450,  334, 434, 1, 1);  // v39 no cooldown after death
        add(0, 1, 0, 0, 320, 450,  334, 434, 1, 0);  // v40
        add(0, 0, 1, 0, 320, 450,  334, 434, 0, 0);  // v41
        add(0, 0, 0, 0, 2040, 10,  334, 434, 0, 0);  // v42
        add(1, 1, 0, 0, 2040, 10,    6,   0, 1, 1);  // v43 X wraps, Y clamps to 0
        add(1, 0, 0, 0, 2040, 10,    6,   0, 0, 0);  // v44 Y=0 retires
        add(0, 0, 1, 0, 320, 450,    6,   0, 0, 0);  // v45
        add(1, 1, 0, 0, 320, 450,  334, 434, 1, 1);  // v46 in flight for reset test

        resetN       = 1'b0;
        startOfFrame = 1'b0;
        fire         = 1'b0;
        playerDead   = 1'b0;
        missileHit   = 1'b0;
        playerX      = 11'd320;
        playerY      = 11'd450;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 11'd0, 11'd0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Asynchronous reset mid-flight with the fire key held through release.
        @(negedge clk);
        startOfFrame = 1'b0;
        fire         = 1'b1;
        #2 resetN = 1'b0;
        #1;
        check_outs("async_rst", 11'd0, 11'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        apply_vec('{1'b0, 1'b1, 1'b0, 1'b0, 11'd320, 11'd450, 11'd0,   11'd0,   1'b0, 1'b0}, "rel0");
        apply_vec('{1'b1, 1'b1, 1'b0, 1'b0, 11'd320, 11'd450, 11'd0,   11'd0,   1'b0, 1'b0}, "rel_held");
        apply_vec('{1'b0, 1'b0, 1'b0, 1'b0, 11'd320, 11'd450, 11'd0,   11'd0,   1'b0, 1'b0}, "rel_up");
        apply_vec('{1'b1, 1'b1, 1'b0, 1'b0, 11'd320, 11'd450, 11'd334, 11'd434, 1'b1, 1'b1}, "rel_fire");
        apply_vec('{1'b0, 1'b1, 1'b0, 1'b0, 11'd320, 11'd450, 11'd334, 11'd434, 1'b1, 1'b0}, "rel_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
